// File: rtl/text_line_writer.sv
// Line editor for the VGA text renderer: append / backspace / clear on a working buffer, vsync-copied to display.
// Latency: edit visible in working buffer 1 edge after accept; display copy on the first edge with vsync_in high.
// Backpressure: in_ready is low for the DEPTH-cycle clear sweep; otherwise every byte is accepted.
module text_line_writer #(
   parameter int         DEPTH      = 65,
   parameter int         CAPACITY   = 40,
   parameter logic [7:0] FILL_CHAR  = 8'h20,
   parameter bit         DOUBLE_BUF = 1'b1
) (
   input  logic       VGA_CLK_IN,
   input  logic       RST_N_IN,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       clear_req,
   input  logic       vsync_in,
   output logic [7:0] ram_out [DEPTH-1:0],
   output logic [6:0] cursor,
   output logic       full,
   output logic       drop
);

   localparam logic [6:0] CAP_L    = 7'(CAPACITY);
   localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
   localparam logic [7:0] BS_CHAR  = 8'h08;
   localparam logic [7:0] CR_CHAR  = 8'h0D;
   localparam logic [7:0] FF_CHAR  = 8'h0C;

   typedef enum logic [0:0] {IDLE, CLEAR} state_t;

   state_t     state;
   logic [6:0] idx;
   logic [7:0] work [DEPTH-1:0];
   logic       accept;
   logic       is_print;

   assign accept   = in_valid & in_ready;
   assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
   assign full     = (cursor == CAP_L);

   // Edit FSM: applies accepted bytes to the working line, or sweeps it blank one cell per cycle.
   always_ff @(posedge VGA_CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         state    <= IDLE;
         in_ready <= 1'b1;
         cursor   <= 7'd0;
         drop     <= 1'b0;
         idx      <= 7'd0;
         for (int i = 0; i < DEPTH; i++) work[i] <= FILL_CHAR;
      end else begin
         drop <= 1'b0;
         case (state)
            IDLE: begin
               // clear_req beats a byte accepted in the same cycle; that byte is simply lost
               if (clear_req) begin
                  state    <= CLEAR;
                  in_ready <= 1'b0;
                  idx      <= 7'd0;
               end else if (accept) begin
                  if (is_print) begin
                     if (!full) begin
                        work[cursor] <= in_data;
                        cursor       <= cursor + 7'd1;
                     end else begin
                        drop <= 1'b1;
                     end
                  end else if (in_data == BS_CHAR) begin
                     if (cursor != 7'd0) begin
                        cursor             <= cursor - 7'd1;
                        work[cursor - 7'd1] <= FILL_CHAR;
                     end
                  end else if (in_data == CR_CHAR || in_data == FF_CHAR) begin
                     state    <= CLEAR;
                     in_ready <= 1'b0;
                     idx      <= 7'd0;
                  end
               end
            end
            CLEAR: begin
               // sweep the whole array, including cells past CAPACITY, so every cell ends at FILL_CHAR
               work[idx] <= FILL_CHAR;
               if (idx == LAST_IDX) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  cursor   <= 7'd0;
               end else begin
                  idx <= idx + 7'd1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   generate
      if (DOUBLE_BUF) begin : g_dbuf
         logic       vsync_q;
         logic       vsync_rise;
         logic [7:0] display [DEPTH-1:0];

         assign vsync_rise = vsync_in & ~vsync_q;

         // Snapshot the working line on the vsync rising edge so the renderer never sees a half-edited frame.
         always_ff @(posedge VGA_CLK_IN or negedge RST_N_IN) begin
            if (!RST_N_IN) begin
               vsync_q <= 1'b0;
               for (int i = 0; i < DEPTH; i++) display[i] <= FILL_CHAR;
            end else begin
               vsync_q <= vsync_in;
               if (vsync_rise) begin
                  for (int i = 0; i < DEPTH; i++) display[i] <= work[i];
               end
            end
         end

         assign ram_out = display;
      end else begin : g_sbuf
         assign ram_out = work;
      end
   endgenerate

endmodule
